// File: rtl/iq_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iq_sched_ctrl
// Function : issue-queue allocation (dispatch -> free slots) and
//            oldest-ready select via an age matrix.
// Revision : 1.0  initial release
// ============================================================================
module iq_sched_ctrl #(
  parameter int ENTRY_COUNT = 8,
  parameter int DISP_WIDTH  = 2,
  parameter int LANE_W      = (DISP_WIDTH > 1) ? $clog2(DISP_WIDTH) : 1,
  parameter int IDX_W       = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [DISP_WIDTH-1:0]         disp_valid_i,
  output logic                          disp_ready_o,
  output logic [ENTRY_COUNT-1:0]        entry_init_o,
  output logic [ENTRY_COUNT*LANE_W-1:0] entry_lane_o,
  input  logic [ENTRY_COUNT-1:0]        entry_ready_i,
  output logic [ENTRY_COUNT-1:0]        entry_select_o,
  output logic                          issue_valid_o,
  input  logic                          issue_ready_i,
  output logic [IDX_W-1:0]              issue_idx_o,
  output logic [IDX_W:0]                count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam logic [IDX_W:0] C_ENTRIES = (IDX_W+1)'(ENTRY_COUNT);
  localparam logic [IDX_W:0] C_LANES   = (IDX_W+1)'(DISP_WIDTH);

  logic [ENTRY_COUNT-1:0]                  r_valid;
  logic [ENTRY_COUNT-1:0][ENTRY_COUNT-1:0] r_age;   // r_age[i][j]: i older than j
  logic [IDX_W:0]                          r_count;

  logic                                    w_kill;
  logic                                    w_disp_ready;
  logic [ENTRY_COUNT-1:0]                  w_init;
  logic [ENTRY_COUNT-1:0][LANE_W-1:0]      w_lane;
  logic [ENTRY_COUNT-1:0][ENTRY_COUNT-1:0] w_older;
  logic [IDX_W:0]                          w_fire_cnt;
  logic                                    w_found;
  logic [ENTRY_COUNT-1:0]                  w_cand;
  logic [ENTRY_COUNT-1:0]                  w_oldest;
  logic [IDX_W-1:0]                        w_idx;
  logic                                    w_hit;
  logic                                    w_issue_valid;
  logic                                    w_issue_fire;
  logic [ENTRY_COUNT-1:0]                  w_select;
  logic [ENTRY_COUNT-1:0][ENTRY_COUNT-1:0] w_age_nxt;

  assign w_kill       = !rst_n || flush;
  assign w_disp_ready = !w_kill && ((C_ENTRIES - r_count) >= C_LANES);

  // Lanes in ascending order each claim the lowest free slot not yet claimed;
  // w_older[k] captures everything that is older than the new occupant of k.
  always_comb begin
    w_init     = '0;
    w_lane     = '0;
    w_older    = '0;
    w_fire_cnt = '0;
    w_found    = 1'b0;
    for (int l = 0; l < DISP_WIDTH; l++) begin
      w_found = 1'b0;
      for (int k = 0; k < ENTRY_COUNT; k++) begin
        if (w_disp_ready && disp_valid_i[l] && !w_found && !r_valid[k] && !w_init[k]) begin
          w_found    = 1'b1;
          w_older[k] = r_valid | w_init;
          w_init[k]  = 1'b1;
          w_lane[k]  = LANE_W'(l);
          w_fire_cnt = w_fire_cnt + (IDX_W+1)'(1);
        end
      end
    end
  end

  assign w_cand = r_valid & entry_ready_i;

  always_comb begin
    w_oldest = '0;
    w_idx    = '0;
    w_hit    = 1'b0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      w_oldest[i] = w_cand[i];
      for (int j = 0; j < ENTRY_COUNT; j++) begin
        if (w_cand[j] && r_age[j][i]) w_oldest[i] = 1'b0;
      end
    end
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      if (w_oldest[i] && !w_hit) begin
        w_idx = IDX_W'(i);
        w_hit = 1'b1;
      end
    end
  end

  assign w_issue_valid = (|w_cand) && !w_kill;
  assign w_issue_fire  = w_issue_valid && issue_ready_i;

  always_comb begin
    w_select = '0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      w_select[i] = w_issue_fire && (w_idx == IDX_W'(i));
    end
  end

  // New slot's column comes from w_older; its row is cleared (youngest).
  always_comb begin
    w_age_nxt = r_age;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      for (int j = 0; j < ENTRY_COUNT; j++) begin
        if (w_init[j])      w_age_nxt[i][j] = w_older[j][i];
        else if (w_init[i]) w_age_nxt[i][j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_valid <= '0;
      r_age   <= '0;
      r_count <= '0;
    end else begin
      r_valid <= (r_valid | w_init) & ~w_select;
      r_age   <= w_age_nxt;
      r_count <= r_count + w_fire_cnt - (IDX_W+1)'(w_issue_fire);
    end
  end

  assign disp_ready_o   = w_disp_ready;
  assign entry_init_o   = w_init;
  assign entry_lane_o   = w_lane;
  assign entry_select_o = w_select;
  assign issue_valid_o  = w_issue_valid;
  assign issue_idx_o    = w_idx;
  assign count_o        = r_count;
  assign full_o         = (r_count == C_ENTRIES);
  assign empty_o        = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_iq_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_sched_ctrl
// Function : directed stimulus for iq_sched_ctrl, checked every cycle
//            against an age-ordered queue model plus literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_iq_sched_ctrl;

  localparam int E  = 8;
  localparam int DW = 2;
  localparam int LW = 1;
  localparam int IW = 3;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [DW-1:0]   disp_valid_i;
  logic            disp_ready_o;
  logic [E-1:0]    entry_init_o;
  logic [E*LW-1:0] entry_lane_o;
  logic [E-1:0]    entry_ready_i;
  logic [E-1:0]    entry_select_o;
  logic            issue_valid_o;
  logic            issue_ready_i;
  logic [IW-1:0]   issue_idx_o;
  logic [IW:0]     count_o;
  logic            full_o;
  logic            empty_o;

  int checks   = 0;
  int failures = 0;

  iq_sched_ctrl #(.ENTRY_COUNT(E), .DISP_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
    .entry_init_o(entry_init_o), .entry_lane_o(entry_lane_o),
    .entry_ready_i(entry_ready_i), .entry_select_o(entry_select_o),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_idx_o(issue_idx_o), .count_o(count_o),
    .full_o(full_o), .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of live slots, oldest first.
  bit            m_valid [E];
  int            m_age [$];
  int            m_count = 0;
  logic          m_kill, e_dr, e_iv;
  logic [E-1:0]  e_init, e_sel;
  logic [E-1:0]  e_lane;
  int            e_idx;
  int            new_slots [$];

  always @(negedge clk) begin
    m_kill = !rst_n || flush;
    e_init = '0; e_lane = '0; e_sel = '0; e_iv = 1'b0; e_idx = 0;
    new_slots.delete();
    e_dr = !m_kill && ((E - m_count) >= DW);
    if (e_dr) begin
      for (int l = 0; l < DW; l++) begin
        if (disp_valid_i[l]) begin
          for (int k = 0; k < E; k++) begin
            if (!m_valid[k] && !e_init[k]) begin
              e_init[k] = 1'b1;
              e_lane[k] = 1'(l);
              new_slots.push_back(k);
              break;
            end
          end
        end
      end
    end
    for (int q = 0; q < m_age.size(); q++) begin
      if (entry_ready_i[m_age[q]]) begin
        e_iv  = 1'b1;
        e_idx = m_age[q];
        break;
      end
    end
    if (m_kill) e_iv = 1'b0;
    if (e_iv && issue_ready_i) e_sel[e_idx] = 1'b1;

    chk("m_disp_ready", 64'(disp_ready_o), 64'(e_dr));
    chk("m_init", 64'(entry_init_o), 64'(e_init));
    chk("m_lane", 64'(entry_lane_o), 64'(e_lane));
    chk("m_issue_valid", 64'(issue_valid_o), 64'(e_iv));
    if (e_iv) chk("m_issue_idx", 64'(issue_idx_o), 64'(e_idx));
    chk("m_select", 64'(entry_select_o), 64'(e_sel));
    chk("m_count", 64'(count_o), 64'(m_count));
    chk("m_full", 64'(full_o), 64'(m_count == E));
    chk("m_empty", 64'(empty_o), 64'(m_count == 0));

    if (m_kill) begin
      foreach (m_valid[k]) m_valid[k] = 1'b0;
      m_age.delete();
      m_count = 0;
    end else begin
      if (e_sel != '0) begin
        m_valid[e_idx] = 1'b0;
        for (int q = 0; q < m_age.size(); q++) begin
          if (m_age[q] == e_idx) begin
            m_age.delete(q);
            break;
          end
        end
        m_count--;
      end
      foreach (new_slots[n]) begin
        m_valid[new_slots[n]] = 1'b1;
        m_age.push_back(new_slots[n]);
        m_count++;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    disp_valid_i = '0; entry_ready_i = '0; issue_ready_i = 1'b0; flush = 1'b0;
    #1;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
  endtask

  task automatic disp(input logic [DW-1:0] lanes, input int n);
    disp_valid_i = lanes;
    cyc(n);
    disp_valid_i = '0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    cyc(2);
    rst_n = 1'b1;
    #1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready_o), 64'd1);
    chk("rst_issue_valid", 64'(issue_valid_o), 64'd0);
    chk("rst_issue_idx", 64'(issue_idx_o), 64'd0);
    chk("rst_init", 64'(entry_init_o), 64'd0);
    chk("rst_select", 64'(entry_select_o), 64'd0);
    chk("rst_lane", 64'(entry_lane_o), 64'd0);

    // Fill 6 slots, then the last two.
    disp_valid_i = 2'b11; #1;
    chk("fill_init0", 64'(entry_init_o), 64'h03);
    chk("fill_lane0", 64'(entry_lane_o), 64'h02);
    cyc();
    chk("fill_init1", 64'(entry_init_o), 64'h0C);
    chk("fill_lane1", 64'(entry_lane_o), 64'h08);
    cyc();
    chk("fill_init2", 64'(entry_init_o), 64'h30);
    cyc();
    chk("fill_count6", 64'(count_o), 64'd6);
    chk("fill_ready6", 64'(disp_ready_o), 64'd1);
    chk("fill_init3", 64'(entry_init_o), 64'hC0);
    cyc();
    disp_valid_i = '0; #1;
    chk("fill_full", 64'(full_o), 64'd1);
    chk("fill_ready8", 64'(disp_ready_o), 64'd0);

    // Oldest-ready select.
    do_flush();
    disp(2'b11, 2);
    entry_ready_i = 8'b0000_1110; issue_ready_i = 1'b1; #1;
    chk("age_idx1", 64'(issue_idx_o), 64'd1);
    chk("age_sel1", 64'(entry_select_o), 64'h02);
    cyc();
    chk("age_idx2", 64'(issue_idx_o), 64'd2);
    cyc();
    chk("age_idx3", 64'(issue_idx_o), 64'd3);
    cyc();
    chk("age_none", 64'(issue_valid_o), 64'd0);
    chk("age_count", 64'(count_o), 64'd1);

    // Reused slot 0 becomes youngest.
    do_flush();
    disp(2'b11, 2);
    entry_ready_i = 8'h01; issue_ready_i = 1'b1; #1;
    chk("reuse_idx0", 64'(issue_idx_o), 64'd0);
    cyc();
    idle();
    disp_valid_i = 2'b01; #1;
    chk("reuse_init", 64'(entry_init_o), 64'h01);
    cyc();
    idle();
    entry_ready_i = 8'hFF; issue_ready_i = 1'b1; #1;
    chk("reuse_o1", 64'(issue_idx_o), 64'd1);
    cyc();
    chk("reuse_o2", 64'(issue_idx_o), 64'd2);
    cyc();
    chk("reuse_o3", 64'(issue_idx_o), 64'd3);
    cyc();
    chk("reuse_o0", 64'(issue_idx_o), 64'd0);
    cyc();
    chk("reuse_empty", 64'(empty_o), 64'd1);
    chk("reuse_iv", 64'(issue_valid_o), 64'd0);

    // count=7 with concurrent issue and full dispatch.
    do_flush();
    disp(2'b11, 3);
    disp(2'b01, 1);
    chk("c7_count", 64'(count_o), 64'd7);
    disp_valid_i = 2'b11; entry_ready_i = 8'h01; issue_ready_i = 1'b1; #1;
    chk("c7_disp_ready", 64'(disp_ready_o), 64'd0);
    chk("c7_init", 64'(entry_init_o), 64'd0);
    chk("c7_select", 64'(entry_select_o), 64'h01);
    cyc();
    idle();
    chk("c7_count6", 64'(count_o), 64'd6);
    disp_valid_i = 2'b11; #1;
    chk("c7_ready", 64'(disp_ready_o), 64'd1);
    chk("c7_init2", 64'(entry_init_o), 64'h81);
    chk("c7_lane2", 64'(entry_lane_o), 64'h80);
    cyc();
    idle();
    chk("c7_full", 64'(full_o), 64'd1);

    // Backpressure: offer held without acceptance.
    entry_ready_i = 8'h02; #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_iv", 64'(issue_valid_o), 64'd1);
      chk("bp_idx", 64'(issue_idx_o), 64'd1);
      chk("bp_sel", 64'(entry_select_o), 64'd0);
      cyc();
    end
    issue_ready_i = 1'b1; #1;
    chk("bp_pulse", 64'(entry_select_o), 64'h02);
    cyc();
    issue_ready_i = 1'b0; #1;
    chk("bp_after", 64'(entry_select_o), 64'd0);
    chk("bp_count", 64'(count_o), 64'd7);
    chk("bp_gone", 64'(issue_valid_o), 64'd0);

    // Flush with 5 live slots; sparse lane 1 fills slot 4.
    do_flush();
    disp(2'b11, 2);
    disp_valid_i = 2'b10; #1;
    chk("sparse_init", 64'(entry_init_o), 64'h10);
    chk("sparse_lane", 64'(entry_lane_o), 64'h10);
    cyc();
    idle();
    chk("fl_count5", 64'(count_o), 64'd5);
    flush = 1'b1; disp_valid_i = 2'b11; entry_ready_i = 8'hFF; issue_ready_i = 1'b1; #1;
    chk("fl_init", 64'(entry_init_o), 64'd0);
    chk("fl_select", 64'(entry_select_o), 64'd0);
    chk("fl_iv", 64'(issue_valid_o), 64'd0);
    chk("fl_dr", 64'(disp_ready_o), 64'd0);
    cyc();
    flush = 1'b0; disp_valid_i = '0; #1;
    chk("fl_count0", 64'(count_o), 64'd0);
    chk("fl_empty", 64'(empty_o), 64'd1);
    chk("fl_iv_after", 64'(issue_valid_o), 64'd0);

    idle();
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
